interface_demux_v2: RTL and testbench

Egress counterpart of the ingress interface mux. It pops frame descriptors and frame bytes from the switch backend's shared egress data/pointer FIFOs and replicates each frame into the per-MAC transmit FIFOs selected by the descriptor's port vector (unicast or multicast). One frame is in flight at a time, in strict backend order. Room is reserved in every destination before the first byte moves, so no mid-frame stall occurs.

---
 rtl/interface_demux_v2.sv | 177 +++++++++++++++++
 tb/tb_interface_demux_v2.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interface_demux_v2.sv
// Egress demux: pops frames from the shared backend FIFOs and replicates each one
// into the per-MAC tx data/pointer FIFOs selected by the descriptor port vector.
module interface_demux_v2 #(
  parameter string IFDMX_MODE = "LLDP",
  localparam bit          LLDP_EN       = (IFDMX_MODE == "LLDP"),
  localparam int unsigned SRC_PTR_WIDTH = LLDP_EN ? 32'd20 : 32'd16,
  localparam int unsigned TX_PTR_WIDTH  = LLDP_EN ? 32'd16 : 32'd12
) (
  input  logic                     clk_sys,
  input  logic                     rstn_sys,
  output logic                     sfifo_rd,
  input  logic [7:0]               sfifo_dout,
  output logic                     ptr_sfifo_rd,
  input  logic [SRC_PTR_WIDTH-1:0] ptr_sfifo_dout,
  input  logic                     ptr_sfifo_empty,
  output logic [7:0]               tx_data_fifo_din,
  output logic [3:0]               tx_data_fifo_wr,
  input  logic [3:0]               tx_data_fifo_afull,
  output logic [TX_PTR_WIDTH-1:0]  tx_ptr_fifo_din,
  output logic [3:0]               tx_ptr_fifo_wr,
  input  logic [3:0]               tx_ptr_fifo_full,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned LEN_W  = 11;
  localparam int unsigned NPORT  = 4;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DROP_W = 16;

  typedef enum logic [6:0] {
    IDLE    = 7'b000_0001,
    PTR_RD  = 7'b000_0010,
    LATCH   = 7'b000_0100,
    WAIT    = 7'b000_1000,
    DATA    = 7'b001_0000,
    DISCARD = 7'b010_0000,
    DESC    = 7'b100_0000
  } state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [NPORT-1:0]        pmap_q, pmap_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    sfifo_rd_q, sfifo_rd_d;
  logic                    ptr_rd_q, ptr_rd_d;
  logic                    vld_q, vld_d;
  logic [BYTE_W-1:0]       din_q, din_d;
  logic [NPORT-1:0]        data_wr_q, data_wr_d;
  logic [NPORT-1:0]        ptr_wr_q, ptr_wr_d;
  logic [TX_PTR_WIDTH-1:0] pdin_q, pdin_d;
  logic [DROP_W-1:0]       drop_q, drop_d;

  logic [LEN_W-1:0]        src_len_c;
  logic [NPORT-1:0]        src_pmap_c;
  logic [TAG_W-1:0]        src_tag_c;
  logic [TX_PTR_WIDTH-1:0] desc_c;
  logic                    room_ok_c;
  logic                    unused_rsvd;

  assign src_len_c   = ptr_sfifo_dout[10:0];
  assign src_pmap_c  = ptr_sfifo_dout[15:12];
  assign unused_rsvd = ptr_sfifo_dout[11];

  // Tag field and tx descriptor layout depend on the descriptor format
  if (LLDP_EN) begin : g_lldp
    assign src_tag_c = ptr_sfifo_dout[SRC_PTR_WIDTH-1 -: TAG_W];
    assign desc_c    = {tag_q, 1'b0, len_q};
  end else begin : g_std
    assign src_tag_c = '0;
    assign desc_c    = {1'b0, len_q};
  end

  // Only ports in the frame's port vector must have room; others are don't-care
  assign room_ok_c = &(~pmap_q | ~(tx_data_fifo_afull | tx_ptr_fifo_full));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    pmap_d   = pmap_q;
    tag_d    = tag_q;
    drop_d   = drop_q;
    pdin_d   = pdin_q;
    ptr_wr_d = '0;

    case (state_q)
      IDLE: begin
        if (!ptr_sfifo_empty) state_d = PTR_RD;
      end
      PTR_RD: begin
        state_d = LATCH;
      end
      LATCH: begin
        len_d  = src_len_c;
        pmap_d = src_pmap_c;
        tag_d  = src_tag_c;
        cnt_d  = LEN_W'(1);
        if (src_len_c == '0) state_d = IDLE;
        else if (src_pmap_c == '0) state_d = DISCARD;
        else state_d = WAIT;
      end
      WAIT: begin
        if (room_ok_c) state_d = DATA;
      end
      DATA: begin
        if (cnt_q == len_q) state_d = DESC;
        else cnt_d = cnt_q + LEN_W'(1);
      end
      DISCARD: begin
        if (cnt_q == len_q) begin
          state_d = IDLE;
          if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      DESC: begin
        // Last byte is in the output register once the read-valid stage is empty
        if (!vld_q) begin
          ptr_wr_d = pmap_q;
          pdin_d   = desc_c;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ptr_rd_d   = (state_d == PTR_RD);
    sfifo_rd_d = (state_d == DATA) || (state_d == DISCARD);
    vld_d      = (state_q == DATA);
    data_wr_d  = vld_q ? pmap_q : '0;
    din_d      = vld_q ? sfifo_dout : din_q;
  end

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      pmap_q     <= '0;
      tag_q      <= '0;
      sfifo_rd_q <= 1'b0;
      ptr_rd_q   <= 1'b0;
      vld_q      <= 1'b0;
      din_q      <= '0;
      data_wr_q  <= '0;
      ptr_wr_q   <= '0;
      pdin_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      pmap_q     <= pmap_d;
      tag_q      <= tag_d;
      sfifo_rd_q <= sfifo_rd_d;
      ptr_rd_q   <= ptr_rd_d;
      vld_q      <= vld_d;
      din_q      <= din_d;
      data_wr_q  <= data_wr_d;
      ptr_wr_q   <= ptr_wr_d;
      pdin_q     <= pdin_d;
      drop_q     <= drop_d;
    end
  end

  assign sfifo_rd         = sfifo_rd_q;
  assign ptr_sfifo_rd     = ptr_rd_q;
  assign tx_data_fifo_din = din_q;
  assign tx_data_fifo_wr  = data_wr_q;
  assign tx_ptr_fifo_din  = pdin_q;
  assign tx_ptr_fifo_wr   = ptr_wr_q;
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_interface_demux_v2.sv
// Bench for interface_demux_v2: backend FIFO model feeds frames, a frame-level
// model predicts every per-port byte and descriptor, a monitor records what the DUT writes.
module tb_interface_demux_v2;

  localparam int unsigned SW = 20;
  localparam int unsigned TW = 16;

  logic           clk_sys = 1'b0;
  logic           rstn_sys;
  logic           sfifo_rd;
  logic [7:0]     sfifo_dout;
  logic           ptr_sfifo_rd;
  logic [SW-1:0]  ptr_sfifo_dout;
  logic           ptr_sfifo_empty;
  logic [7:0]     tx_data_fifo_din;
  logic [3:0]     tx_data_fifo_wr;
  logic [3:0]     tx_data_fifo_afull;
  logic [TW-1:0]  tx_ptr_fifo_din;
  logic [3:0]     tx_ptr_fifo_wr;
  logic [3:0]     tx_ptr_fifo_full;
  logic [15:0]    drop_cnt;

  always #5 clk_sys = ~clk_sys;

  interface_demux_v2 #(.IFDMX_MODE("LLDP")) u_dut (
    .clk_sys            (clk_sys),
    .rstn_sys           (rstn_sys),
    .sfifo_rd           (sfifo_rd),
    .sfifo_dout         (sfifo_dout),
    .ptr_sfifo_rd       (ptr_sfifo_rd),
    .ptr_sfifo_dout     (ptr_sfifo_dout),
    .ptr_sfifo_empty    (ptr_sfifo_empty),
    .tx_data_fifo_din   (tx_data_fifo_din),
    .tx_data_fifo_wr    (tx_data_fifo_wr),
    .tx_data_fifo_afull (tx_data_fifo_afull),
    .tx_ptr_fifo_din    (tx_ptr_fifo_din),
    .tx_ptr_fifo_wr     (tx_ptr_fifo_wr),
    .tx_ptr_fifo_full   (tx_ptr_fifo_full),
    .drop_cnt           (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backpressure source: manual values or random per-cycle values
  logic       bp_rand = 1'b0;
  logic [3:0] man_afull = 4'b0, man_full = 4'b0;
  logic [3:0] rnd_afull = 4'b0, rnd_full = 4'b0;
  assign tx_data_fifo_afull = bp_rand ? rnd_afull : man_afull;
  assign tx_ptr_fifo_full   = bp_rand ? rnd_full  : man_full;

  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      rnd_afull = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0;
      rnd_full  = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
    end
  end

  // Backend FIFOs: registered read data, cleared by the shared reset
  logic [SW-1:0] ptr_q[$];
  logic [7:0]    dat_q[$];
  int            underflow = 0;

  always @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      ptr_q.delete();
      dat_q.delete();
      ptr_sfifo_dout  <= '0;
      sfifo_dout      <= '0;
      ptr_sfifo_empty <= 1'b1;
    end else begin
      if (ptr_sfifo_rd) begin
        if (ptr_q.size() > 0) ptr_sfifo_dout <= ptr_q.pop_front();
        else underflow++;
      end
      if (sfifo_rd) begin
        if (dat_q.size() > 0) sfifo_dout <= dat_q.pop_front();
        else underflow++;
      end
      ptr_sfifo_empty <= (ptr_q.size() == 0);
    end
  end

  // Monitor: per-port write events in cycle order, ports low to high within a cycle
  logic [11:0]   got_data[$];
  logic [TW+1:0] got_desc[$];
  int            rd_cnt  = 0;
  int            overlap = 0;

  always @(negedge clk_sys) begin
    if (!rstn_sys) begin
      got_data.delete();
      got_desc.delete();
      rd_cnt = 0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (tx_data_fifo_wr[n]) got_data.push_back({4'(n), tx_data_fifo_din});
        if (tx_ptr_fifo_wr[n])  got_desc.push_back({2'(n), tx_ptr_fifo_din});
      end
      if ((|tx_data_fifo_wr) && (|tx_ptr_fifo_wr)) overlap++;
      if (sfifo_rd) rd_cnt++;
    end
  end

  // Reference model: what each queued frame must produce
  logic [11:0]   exp_data[$];
  logic [TW+1:0] exp_desc[$];
  int            exp_rds   = 0;
  int            exp_drops = 0;

  task automatic push_frame(input logic [3:0] pmap, input int len, input logic [3:0] tag,
                            input bit incr);
    logic [7:0] b;
    ptr_q.push_back({tag, pmap, 1'($urandom), 11'(len)});
    exp_rds += len;
    if (len != 0 && pmap == 4'b0 && exp_drops < 65535) exp_drops++;
    for (int i = 0; i < len; i++) begin
      b = incr ? 8'(i) : 8'($urandom);
      dat_q.push_back(b);
      for (int n = 0; n < 4; n++)
        if (pmap[n]) exp_data.push_back({4'(n), b});
    end
    if (len != 0 && pmap != 4'b0)
      for (int n = 0; n < 4; n++)
        if (pmap[n]) exp_desc.push_back({2'(n), tag, 1'b0, 11'(len)});
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (!(ptr_q.size() == 0 && dat_q.size() == 0 && got_desc.size() >= exp_desc.size())
           && cyc < 5000) begin
      @(posedge clk_sys);
      cyc++;
    end
    check_eq({tag, "_drain_in_time"}, 32'(cyc < 5000), 32'd1);
    repeat (6) @(posedge clk_sys);
    #1;
  endtask

  task automatic compare(input string tag);
    int bad;
    check_eq({tag, "_ndata"}, got_data.size(), exp_data.size());
    bad = -1;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
      if (got_data[i] !== exp_data[i]) begin bad = i; break; end
    check_eq({tag, "_data_first_bad_idx"}, bad, -1);
    check_eq({tag, "_ndesc"}, got_desc.size(), exp_desc.size());
    bad = -1;
    for (int i = 0; i < exp_desc.size() && i < got_desc.size(); i++)
      if (got_desc[i] !== exp_desc[i]) begin bad = i; break; end
    check_eq({tag, "_desc_first_bad_idx"}, bad, -1);
    check_eq({tag, "_sfifo_rd_count"}, rd_cnt, exp_rds);
    check_eq({tag, "_drop_cnt"}, {16'b0, drop_cnt}, exp_drops);
    check_eq({tag, "_strobe_overlap"}, overlap, 0);
    check_eq({tag, "_backend_underflow"}, underflow, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, base, cyc, len;
    rstn_sys = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("rst_sfifo_rd",  32'(sfifo_rd), 0);
    check_eq("rst_ptr_rd",    32'(ptr_sfifo_rd), 0);
    check_eq("rst_data_wr",   32'(tx_data_fifo_wr), 0);
    check_eq("rst_ptr_wr",    32'(tx_ptr_fifo_wr), 0);
    check_eq("rst_data_din",  32'(tx_data_fifo_din), 0);
    check_eq("rst_ptr_din",   32'(tx_ptr_fifo_din), 0);
    check_eq("rst_drop_cnt",  32'(drop_cnt), 0);
    rstn_sys = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // Unicast, incrementing bytes
    push_frame(4'b0100, 64, 4'h0, 1'b1);
    wait_drain("unicast");
    compare("unicast");

    // Multicast to ports 0,1,3
    push_frame(4'b1011, 100, 4'h0, 1'b0);
    wait_drain("mcast");
    compare("mcast");

    // Backpressure from a selected port holds the frame; unrelated port 2 never blocks
    man_afull = 4'b0110;
    push_frame(4'b0011, 40, 4'h0, 1'b0);
    rd0 = rd_cnt;
    repeat (20) @(posedge clk_sys);
    #1;
    check_eq("bp_no_rd_while_afull", rd_cnt - rd0, 0);
    man_afull = 4'b0100;
    @(posedge clk_sys);
    #1;
    check_eq("bp_rd_after_release", 32'(sfifo_rd), 1);
    wait_drain("bp");
    compare("bp");
    man_afull = 4'b0;

    // Discard and zero-length frames
    push_frame(4'b0000, 60, 4'h0, 1'b0);
    wait_drain("discard");
    compare("discard");
    push_frame(4'b0001, 0, 4'h0, 1'b0);
    wait_drain("zero_len");
    compare("zero_len");
    check_eq("zero_len_drop_still_1", 32'(drop_cnt), 1);

    // Back-to-back LLDP-tagged frames queued together
    push_frame(4'b1001, 60, 4'hA, 1'b0);
    push_frame(4'b0110, 1518, 4'h5, 1'b0);
    wait_drain("lldp_b2b");
    compare("lldp_b2b");

    // Random frames under random backpressure
    bp_rand = 1'b1;
    for (int f = 0; f < 14; f++) begin
      case ($urandom_range(3))
        0:       len = 0;
        1:       len = 1;
        default: len = int'($urandom_range(90, 2));
      endcase
      push_frame(4'($urandom), len, 4'($urandom), 1'b0);
    end
    wait_drain("random");
    compare("random");
    bp_rand = 1'b0;

    // Reset in the middle of a frame
    push_frame(4'b0001, 64, 4'h3, 1'b1);
    base = got_data.size();
    cyc = 0;
    while (got_data.size() - base < 30 && cyc < 2000) begin
      @(posedge clk_sys);
      #1;
      cyc++;
    end
    check_eq("mid_rst_reached_byte30", 32'(cyc < 2000), 1);
    rstn_sys = 1'b0;
    #1;
    check_eq("mid_rst_sfifo_rd", 32'(sfifo_rd), 0);
    check_eq("mid_rst_ptr_rd",   32'(ptr_sfifo_rd), 0);
    check_eq("mid_rst_data_wr",  32'(tx_data_fifo_wr), 0);
    check_eq("mid_rst_ptr_wr",   32'(tx_ptr_fifo_wr), 0);
    check_eq("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    exp_data.delete();
    exp_desc.delete();
    exp_rds   = 0;
    exp_drops = 0;
    repeat (2) @(posedge clk_sys);
    #1;
    rstn_sys = 1'b1;
    @(posedge clk_sys);
    #1;
    push_frame(4'b1000, 33, 4'hC, 1'b0);
    wait_drain("post_rst");
    compare("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
